and_gate: RTL and testbench
===========================

// Module: and_gate
//
// PURPOSE
//   Bitwise two-input AND primitive used as a basic-gate building block.
//   Out is I0 & I1 per bit, with an optional registered output stage and an
//   enable/valid qualifier so the block can drop straight into clocked datapaths.
//   Default configuration (WIDTH=1) is a single AND gate with one-cycle latency.
//
// PARAMETERS
//   WIDTH    1   bit width of I0, I1 and Out (>=1)
//   REG_OUT  1   1: output registered on clk (1-cycle latency); 0: purely combinational
//
// PORTS
//   clk        in   1      clock; rising-edge active
//   rst        in   1      reset; synchronous, active-high
//   en         in   1      input qualifier; sample/propagate I0,I1 when high
//   I0         in   WIDTH  operand A
//   I1         in   WIDTH  operand B
//   Out        out  WIDTH  bitwise AND result I0 & I1
//   out_valid  out  1      Out holds a freshly computed result
//   all_ones   out  1      reduction AND of Out (every bit 1)
//   any_one    out  1      reduction OR of Out (at least one bit 1)
//   Interface rule: one clock (clk); reset rst is synchronous and active-high.
//
// BEHAVIOUR
//   - Function: Out[i] = I0[i] & I1[i] for every i in [0, WIDTH-1]; no carries, no
//     cross-bit interaction. Truth table per bit: 00->0, 01->0, 10->0, 11->1.
//   - all_ones = &Out, any_one = |Out; always derived from current Out (no extra latency).
//   - REG_OUT=1:
//     * rising clk with rst=1: Out=0, out_valid=0 (so all_ones=0, any_one=0);
//       rst has priority over en.
//     * rising clk, rst=0, en=1: Out <= I0 & I1, out_valid <= 1.
//     * rising clk, rst=0, en=0: Out holds previous value, out_valid <= 0.
//     * Latency exactly 1 cycle from sampled inputs to Out; throughput 1 per cycle.
//     * Reset asserted mid-stream discards the in-flight result on that edge.
//     * Before the first clock edge, outputs are undefined (no initial values relied on).
//   - REG_OUT=0:
//     * Out = I0 & I1 continuously (zero latency); out_valid = en; clk/rst unused.
//   - X/Z inputs: follow Verilog & semantics (0 & X = 0, 1 & X = X); no
//     sanitisation.
//   - WIDTH < 1 is illegal; the build must fail (elaboration error).
//
// TESTING
//   1. WIDTH=1, REG_OUT=1: rst=1 for 1 edge -> Out=0, out_valid=0, all_ones=0, any_one=0.
//   2. WIDTH=1, en=1, apply (I0,I1) = 00,01,10,11 on consecutive edges -> Out one
//      cycle later = 0,0,0,1; out_valid=1 each cycle; all_ones=any_one=Out.
//   3. WIDTH=1: Out=1 held, then en=0 with I0=0 -> Out stays 1, out_valid=0.
//   4. WIDTH=1: en=1 and rst=1 on the same edge with I0=I1=1 -> Out=0, out_valid=0.
//   5. WIDTH=8, en=1: I0=8'hF0, I1=8'h3C -> Out=8'h30, all_ones=0, any_one=1; then
//      I0=I1=8'hFF -> Out=8'hFF, all_ones=1.
//   6. WIDTH=1, REG_OUT=0: sweep 00,01,10,11 with #1 between steps, no clock ->
//      Out=0,0,0,1 after each step; out_valid tracks en.

Source files
------------

// File: rtl/and_gate.sv
// Bitwise two-input AND with optional registered output stage.
// Reduction flags all_ones/any_one always follow the visible Out.
module and_gate #(
  parameter int WIDTH   = 1,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  output logic [WIDTH-1:0] Out,
  output logic             out_valid,
  output logic             all_ones,
  output logic             any_one
);

  if (WIDTH < 1) begin : g_bad_width
    $error("and_gate: WIDTH must be >= 1");
  end

  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;

    // Capture a fresh product when qualified, else hold data and drop valid.
    always_comb begin
      out_d   = out_q;
      valid_d = 1'b0;
      if (en) begin
        out_d   = I0 & I1;
        valid_d = 1'b1;
      end
    end

    // Output register; reset wins over en and discards in-flight data.
    always_ff @(posedge clk) begin
      if (rst) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        out_q   <= out_d;
        valid_q <= valid_d;
      end
    end

    assign Out       = out_q;
    assign out_valid = valid_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign Out       = I0 & I1;
    assign out_valid = en;
  end

  assign all_ones = &Out;
  assign any_one  = |Out;

endmodule

// File: tb/tb_and_gate.sv
// Self-checking bench for and_gate: registered W=1, registered W=8,
// and combinational W=1 instances sharing one clock.
module tb_and_gate;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // registered, WIDTH=1
  logic       rst1, en1;
  logic [0:0] a1, b1, o1;
  logic       v1, ao1, an1;
  // registered, WIDTH=8
  logic       rst8, en8;
  logic [7:0] a8, b8, o8;
  logic       v8, ao8, an8;
  // combinational, WIDTH=1
  logic       rstc, enc;
  logic [0:0] ac, bc, oc;
  logic       vc, aoc, anc;

  and_gate #(.WIDTH(1), .REG_OUT(1)) u_r1 (
    .clk(clk), .rst(rst1), .en(en1), .I0(a1), .I1(b1),
    .Out(o1), .out_valid(v1), .all_ones(ao1), .any_one(an1)
  );

  and_gate #(.WIDTH(8), .REG_OUT(1)) u_r8 (
    .clk(clk), .rst(rst8), .en(en8), .I0(a8), .I1(b8),
    .Out(o8), .out_valid(v8), .all_ones(ao8), .any_one(an8)
  );

  and_gate #(.WIDTH(1), .REG_OUT(0)) u_c1 (
    .clk(clk), .rst(rstc), .en(enc), .I0(ac), .I1(bc),
    .Out(oc), .out_valid(vc), .all_ones(aoc), .any_one(anc)
  );

  typedef struct {
    logic rst;
    logic en;
    logic i0;
    logic i1;
    logic exp_out;
    logic exp_v;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic       v;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    vec_t tbl[10];
    exp_t e;
    logic [7:0] last8;
    logic [7:0] ra, rb;
    logic       ren;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst1 = 1'b1; en1 = 1'b0; a1 = '0; b1 = '0;
    rst8 = 1'b1; en8 = 1'b0; a8 = '0; b8 = '0;
    rstc = 1'b0; enc = 1'b0; ac = '0; bc = '0;

    // table-driven W=1 registered sequence
    for (int i = 0; i < 10; i++) begin
      rst1 = tbl[i].rst;
      en1  = tbl[i].en;
      a1   = tbl[i].i0;
      b1   = tbl[i].i1;
      q1.push_back('{{7'd0, tbl[i].exp_out}, tbl[i].exp_v});
      @(posedge clk);
      #1;
      e = q1.pop_front();
      chk($sformatf("w1_out[%0d]", i), {7'd0, o1}, e.out);
      chk($sformatf("w1_valid[%0d]", i), {7'd0, v1}, {7'd0, e.v});
      chk($sformatf("w1_all[%0d]", i), {7'd0, ao1}, {7'd0, e.out[0]});
      chk($sformatf("w1_any[%0d]", i), {7'd0, an1}, {7'd0, e.out[0]});
    end
    rst1 = 1'b0; en1 = 1'b0;

    // W=8 reset then hand-written pattern
    @(posedge clk);
    #1;
    chk("w8_rst_out", o8, 8'h00);
    chk("w8_rst_valid", {7'd0, v8}, 8'd0);
    chk("w8_rst_any", {7'd0, an8}, 8'd0);

    rst8 = 1'b0; en8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
    @(posedge clk);
    #1;
    chk("w8_f0_3c_out", o8, 8'h30);
    chk("w8_f0_3c_all", {7'd0, ao8}, 8'd0);
    chk("w8_f0_3c_any", {7'd0, an8}, 8'd1);
    chk("w8_f0_3c_valid", {7'd0, v8}, 8'd1);

    a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk);
    #1;
    chk("w8_ff_out", o8, 8'hFF);
    chk("w8_ff_all", {7'd0, ao8}, 8'd1);
    chk("w8_ff_any", {7'd0, an8}, 8'd1);
    last8 = 8'hFF;

    // W=8 random stream through scoreboard queue
    for (int i = 0; i < 24; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      ren = ($urandom_range(3) != 0);
      a8 = ra; b8 = rb; en8 = ren;
      if (ren) last8 = ra & rb;
      q8.push_back('{last8, ren});
      @(posedge clk);
      #1;
      e = q8.pop_front();
      chk($sformatf("w8_rnd_out[%0d]", i), o8, e.out);
      chk($sformatf("w8_rnd_valid[%0d]", i), {7'd0, v8}, {7'd0, e.v});
      chk($sformatf("w8_rnd_all[%0d]", i), {7'd0, ao8},
          {7'd0, (e.out == 8'hFF)});
      chk($sformatf("w8_rnd_any[%0d]", i), {7'd0, an8},
          {7'd0, (e.out != 8'h00)});
    end

    // mid-stream reset discards in-flight product
    en8 = 1'b1; rst8 = 1'b1; a8 = 8'hAA; b8 = 8'hFF;
    @(posedge clk);
    #1;
    chk("w8_midrst_out", o8, 8'h00);
    chk("w8_midrst_valid", {7'd0, v8}, 8'd0);
    rst8 = 1'b0; en8 = 1'b0;

    // combinational instance, no clock dependence
    for (int i = 0; i < 4; i++) begin
      ac  = 1'(i >> 1);
      bc  = 1'(i);
      enc = 1'(i);
      #1;
      chk($sformatf("c1_out[%0d]", i), {7'd0, oc}, {7'd0, (i == 3)});
      chk($sformatf("c1_valid[%0d]", i), {7'd0, vc}, {7'd0, 1'(i)});
      chk($sformatf("c1_all[%0d]", i), {7'd0, aoc}, {7'd0, (i == 3)});
      chk($sformatf("c1_any[%0d]", i), {7'd0, anc}, {7'd0, (i == 3)});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
